// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger peripheral.
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_e;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_WIDTH_L = 3'd2;
  localparam logic [2:0] ADDR_WIDTH_H = 3'd3;
  localparam logic [2:0] ADDR_AVG_L   = 3'd4;
  localparam logic [2:0] ADDR_AVG_H   = 3'd5;

  localparam int unsigned STAT_DONE  = 0;
  localparam int unsigned STAT_TO    = 1;
  localparam int unsigned STAT_BUSY  = 2;

  localparam int unsigned CTRL_IE    = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  localparam logic [31:0] WIDTH_TIMEOUT = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Echo input synchroniser (SYNC_STAGES flops) followed by an edge-detect flop.
module echo_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic echo_s,
  output logic echo_rise,
  output logic echo_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], echo};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign echo_s    = sync_q[SYNC_STAGES-1];
  assign echo_rise =  echo_s & ~edge_q;
  assign echo_fall = ~echo_s &  edge_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Avalon-MM HC-SR04 ranger: trigger pulse, echo high-time measurement, irq on DONE.
// Optional 4-sample moving average on addr 4/5 enabled by `define ULTRASONIC_AVG_EN.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        trig,
  input  logic        echo
);

  state_e      state_q, state_d, exit_state;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] width_q, width_d;
  logic        done_q, done_d, to_q, to_d;
  logic        ie_q, ie_d, cont_q, cont_d;
  logic [15:0] readdata_q, readdata_d;
  logic        busy;
  logic        meas_ok, meas_to;
  logic        echo_s, echo_rise, echo_fall;
  logic [31:0] avg_w;

  logic wr, wr_status, wr_ctrl, wr_avg, start, stop;
  logic unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_status = wr && (address == ADDR_STATUS);
  assign wr_ctrl   = wr && (address == ADDR_CONTROL);
  assign wr_avg    = wr && (address == ADDR_AVG_L);
  assign start     = wr_ctrl & writedata[CTRL_START];
  assign stop      = wr_ctrl & writedata[CTRL_STOP];
  assign unused_wdata = ^writedata[15:4];

  echo_sync #(.SYNC_STAGES(SYNC_STAGES)) u_echo_sync (
    .clk       (clk),
    .rst_n     (reset_n),
    .echo      (echo),
    .echo_s    (echo_s),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM: next state. cnt_q times the trigger pulse, then the timeout window.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    meas_ok    = 1'b0;
    meas_to    = 1'b0;
    exit_state = cont_q ? TRIG : IDLE;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q >= TRIG_CYCLES - 1) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_RISE: begin
        cnt_d = cnt_q + 32'd1;
        if (echo_rise) begin
          state_d = MEASURE;
          wcnt_d  = 32'd1;
        end else if (cnt_q >= TIMEOUT_CYCLES - 1) begin
          meas_to = 1'b1;
          state_d = exit_state;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + 32'd1;
        if (echo_fall) begin
          meas_ok = 1'b1;
          state_d = exit_state;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_CYCLES - 1) begin
          meas_to = 1'b1;
          state_d = exit_state;
          cnt_d   = '0;
        end else if (echo_s) begin
          wcnt_d = sat_inc(wcnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // STOP aborts without recording anything, and overrides any START.
    if (stop) begin
      state_d = IDLE;
      meas_ok = 1'b0;
      meas_to = 1'b0;
    end
  end

  // FSM: outputs
  always_comb begin
    trig = (state_q == TRIG);
    busy = (state_q != IDLE);
  end

  always_comb begin
    done_d  = done_q;
    to_d    = to_q;
    width_d = width_q;
    ie_d    = ie_q;
    cont_d  = cont_q;
    if (wr_status) begin
      done_d = 1'b0;
      to_d   = 1'b0;
    end
    if (meas_ok) begin
      done_d  = 1'b1;
      width_d = wcnt_q;
    end
    if (meas_to) begin
      done_d  = 1'b1;
      to_d    = 1'b1;
      width_d = WIDTH_TIMEOUT;
    end
    if (wr_ctrl) begin
      ie_d   = writedata[CTRL_IE];
      cont_d = writedata[CTRL_CONT];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      width_q <= '0;
      ie_q    <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      done_q  <= done_d;
      to_q    <= to_d;
      width_q <= width_d;
      ie_q    <= ie_d;
      cont_q  <= cont_d;
    end
  end

  assign irq = done_q & ie_q;

`ifdef ULTRASONIC_AVG_EN
  logic [31:0] hist_q [4];
  logic [31:0] hist_d [4];
  logic [33:0] sum_q, sum_d;

  always_comb begin
    hist_d = hist_q;
    if (wr_avg) begin
      for (int unsigned i = 0; i < 4; i++) hist_d[i] = '0;
    end else if (meas_ok) begin
      hist_d[0] = wcnt_q;
      for (int unsigned i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
    end
    sum_d = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
          + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
      sum_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  assign avg_w = sum_q[33:2];
`else
  assign avg_w = '0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STAT_DONE] = done_q;
        readdata_d[STAT_TO]   = to_q;
        readdata_d[STAT_BUSY] = busy;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_IE]   = ie_q;
        readdata_d[CTRL_CONT] = cont_q;
      end
      ADDR_WIDTH_L: readdata_d = width_q[15:0];
      ADDR_WIDTH_H: readdata_d = width_q[31:16];
      ADDR_AVG_L:   readdata_d = avg_w[15:0];
      ADDR_AVG_H:   readdata_d = avg_w[31:16];
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Avalon-MM slave peripheral on the Nios bus that drives an HC-SR04-class ultrasonic sensor.
- Issues a trigger pulse, then measures the echo high-time in clk cycles.
- Latches the result and raises irq.
- Sits beside the interval timer: the timer ISR paces measurement starts, and this block delivers distance samples to the theremin pitch/volume software.

Parameters:
- TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000, maximum cycles from trigger end to echo fall before timeout (30 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop depth of the echo input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  interrupt, level, active-high
- trig  out  1  sensor trigger output
- echo  in  1  asynchronous sensor echo input

Behaviour:
- Clocking and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: readdata 0, irq 0, trig 0, FSM IDLE, width 0, status 0, control 0.
- Register map:
  - addr 0 STATUS: bit0 DONE, bit1 TO, bit2 BUSY. Any write clears DONE and TO.
  - addr 1 CONTROL: bit0 IE, bit1 CONT. Writes store bits[1:0]. writedata[2]=START and writedata[3]=STOP are strobes and are not stored.
  - addr 2 WIDTH_L = width[15:0]; addr 3 WIDTH_H = width[31:16].
  - addr 4/5: see Optional Feature. Other addresses read 0.
- Read path: readdata is the read mux registered every cycle (1-cycle read latency, chipselect ignored for reads).
- Write strobe: chipselect && ~write_n && address match.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE.
  - IDLE: trig=0. START -> TRIG, counter cleared.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles -> WAIT_RISE; the timeout counter clears on entry.
  - WAIT_RISE: trig=0, timeout counter increments. Synchronised rising edge of echo -> MEASURE with width counter = 1. Timeout counter reaching TIMEOUT_CYCLES-1 -> timeout exit.
  - MEASURE: width counter +1 per cycle while echo high; timeout counter keeps running. Falling edge -> width latched, DONE=1, exit. Timeout -> timeout exit.
  - Timeout exit: TO=1, DONE=1, width latched as 32'hFFFFFFFF.
  - Exit target: CONT=1 -> TRIG, otherwise IDLE.
- BUSY = (state != IDLE).
- irq = (DONE && IE), combinational from registers.
- Echo sampling: echo passes through SYNC_STAGES flops plus one edge-detect flop, giving SYNC_STAGES+1 cycles of latency. Width counts synchronised high-time exactly.
- Width counter is 32-bit and saturates at all-ones; it cannot wrap because timeout fires first.
- Simultaneous events:
  - START while BUSY is ignored.
  - STOP -> IDLE next cycle and trig=0; DONE/TO/width unchanged; STOP beats START in the same write.
  - Status clear in the same cycle as a DONE/TO set: set wins.
  - A CONTROL write clearing CONT mid-measurement completes the current measurement, then -> IDLE.
- Echo already high at WAIT_RISE entry: no rising edge occurs, so the block waits; a stuck-high echo ends in timeout.
- Reset mid-operation: trig drops asynchronously and all state returns to reset values.

Optional Feature:
- Macro ULTRASONIC_AVG_EN.
- Defined:
  - 4-entry shift history of non-timeout widths, reset to 0.
  - addr 4/5 read the low/high halves of (sum of 4 entries)>>2.
  - The sum is registered and updates 1 cycle after DONE.
  - Any write to addr 4 clears the history.
- Undefined: no history logic; addr 4/5 read 0 and writes to them are ignored.

Decomposition:
- Package ultrasonic_pkg:
  - state enum {IDLE, TRIG, WAIT_RISE, MEASURE}
  - address constants ADDR_STATUS..ADDR_AVG_H
  - status/control bit-position constants
  - WIDTH_TIMEOUT = 32'hFFFFFFFF
- Sub-module echo_sync: SYNC_STAGES synchroniser plus edge detector. Outputs echo_s, echo_rise, echo_fall.

Test Plan:
- Reset, then read addrs 0-5 -> all 0, trig 0, irq 0.
- Write CONTROL=0x5 (IE+START); echo high for 1000 cycles starting 200 cycles after trig falls -> trig high exactly 500 cycles; width reads 1000 (WIDTH_L=0x03E8, WIDTH_H=0); STATUS=0x1; irq=1. A write to STATUS drops irq next cycle.
- TIMEOUT_CYCLES=2000, START, echo held low -> DONE=1, TO=1, width=0xFFFFFFFF, state IDLE, BUSY=0.
- CONTROL=0x6 (CONT+START), echo widths 100/200/300 -> three back-to-back trig pulses; width updates to each value in turn; BUSY stays 1. Then write STOP -> trig=0 and IDLE within 1 cycle.
- STOP issued mid-MEASURE, and START issued while BUSY -> previous width retained, no DONE, START ignored.
- With ULTRASONIC_AVG_EN: widths 100, 200, 300, 400 -> AVG_L reads 250. A timeout sample leaves AVG unchanged. Without the macro, addr 4 reads 0.
